// File: rtl/add_seq_pkg.sv
// Shared types and constants for the sequential nibble adder/arbiter.
package add_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   localparam int unsigned WIDTH_DEFAULT = 32;
   localparam int unsigned NIBBLES       = WIDTH_DEFAULT / 4;

   // Number of 4-bit slice passes needed for a given operand width.
   function automatic int unsigned nibbles_of(input int unsigned width);
      return width / 4;
   endfunction

endpackage

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:1] c;

   // Flattened lookahead carries, no ripple between bit positions.
   always_comb begin
      g    = a_i & b_i;
      p    = a_i ^ b_i;
      c[1] = g[0] | (p[0] & cin_i);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin_i);
      sum_o  = p ^ {c[3:1], cin_i};
      cout_o = c[4];
   end

endmodule

// File: rtl/add_seq_arb.sv
// Two-requester round-robin front end to a time-shared 4-bit CLA slice that
// adds or subtracts WIDTH-bit operands one nibble per cycle, LSB first.
// Optional signed-overflow output is built when ADD_SEQ_OVF_EN is defined.
module add_seq_arb
   import add_seq_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout
`ifdef ADD_SEQ_OVF_EN
   ,
   output logic             rsp_ovf
`endif
);

   localparam int unsigned     Nib     = nibbles_of(WIDTH);
   localparam int unsigned     CntW    = (Nib > 1) ? $clog2(Nib) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(Nib - 1);

   state_e           state_q;
   logic             prio_q;
   logic             id_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CntW-1:0]  cnt_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_sum_q;
   logic             rsp_cout_q;

   logic             gnt_vld;
   logic             gnt_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_sub;
   logic [3:0]       slice_sum;
   logic             slice_cout;
   logic [WIDTH-1:0] acc_next;

`ifdef ADD_SEQ_OVF_EN
   logic rsp_ovf_q;
   logic msb_cin;
   // Carry into the MSB recovered from the final slice: sum ^ a ^ b at bit 3.
   assign msb_cin = slice_sum[3] ^ a_q[3] ^ b_q[3];
   assign rsp_ovf = rsp_ovf_q;
`endif

   cla4 u_cla4 (
      .a_i    (a_q[3:0]),
      .b_i    (b_q[3:0]),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   // a_q doubles as the result accumulator: sum nibbles enter at the top.
   assign acc_next = {slice_sum, a_q[WIDTH-1:4]};

   // Round-robin grant and operand mux; prio_q names the requester that wins a tie.
   always_comb begin
      gnt_vld = req0_valid | req1_valid;
      gnt_id  = (req0_valid && req1_valid) ? prio_q : req1_valid;
      op_a    = gnt_id ? req1_a   : req0_a;
      op_b    = gnt_id ? req1_b   : req0_b;
      op_sub  = gnt_id ? req1_sub : req0_sub;
   end

   assign req0_ready = (state_q == StIdle) && gnt_vld && !gnt_id;
   assign req1_ready = (state_q == StIdle) && gnt_vld && gnt_id;

   // Control FSM, operand shifters and registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         prio_q      <= 1'b0;
         id_q        <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         rsp_ovf_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_vld) begin
                  a_q     <= op_a;
                  b_q     <= op_sub ? ~op_b : op_b;
                  carry_q <= op_sub;
                  id_q    <= gnt_id;
                  prio_q  <= ~gnt_id;
                  cnt_q   <= '0;
                  state_q <= StCalc;
               end
            end
            StCalc: begin
               a_q     <= acc_next;
               b_q     <= {4'b0000, b_q[WIDTH-1:4]};
               carry_q <= slice_cout;
               cnt_q   <= cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  state_q     <= StDone;
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_sum_q   <= acc_next;
                  rsp_cout_q  <= slice_cout;
`ifdef ADD_SEQ_OVF_EN
                  rsp_ovf_q   <= msb_cin ^ slice_cout;
`endif
               end
            end
            StDone: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_add_seq_arb.sv
// Self-checking bench for add_seq_arb (WIDTH=32): directed table, corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_add_seq_arb;

   localparam int unsigned W   = 32;
   localparam int unsigned NIB = W / 4;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req0_ready, req0_sub;
   logic         req1_valid, req1_ready, req1_sub;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
   logic [W-1:0] rsp_sum;
`ifdef ADD_SEQ_OVF_EN
   logic         rsp_ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic prio;   // model round-robin pointer: requester favoured on a tie

   add_seq_arb #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout)
`ifdef ADD_SEQ_OVF_EN
      ,
      .rsp_ovf    (rsp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         v0;
      logic         v1;
      logic [W-1:0] a0;
      logic [W-1:0] b0;
      logic         s0;
      logic [W-1:0] a1;
      logic [W-1:0] b1;
      logic         s1;
      logic         id;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           hold;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference arithmetic: plain integer add/subtract on W-bit values.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] sum, output logic c, output logic ov);
      logic [W:0] f;
      if (s) begin
         sum = a - b;
         c   = (a >= b);
         ov  = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
      end else begin
         f   = {1'b0, a} + {1'b0, b};
         sum = f[W-1:0];
         c   = f[W];
         ov  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_outputs", 64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}), 64'd0);
`ifdef ADD_SEQ_OVF_EN
      check("reset_ovf", 64'(rsp_ovf), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      prio  = 1'b0;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_txn(input logic v0, input logic v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic s0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1,
                          input logic exp_id, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf,
                          input int hold, input string tag);
      logic early;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
      rsp_ready  = 1'b0;
      #1;
      check({tag, "/grant"}, 64'({req0_ready, req1_ready}),
            64'({v0 && !exp_id, v1 && exp_id}));
      prio = ~exp_id;
      @(negedge clk);
      // Operands must already be latched; scramble them.
      req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom);
      early = 1'b0;
      for (int k = 0; k < NIB; k++) begin
         if (rsp_valid) early = 1'b1;
         @(negedge clk);
      end
      check({tag, "/latency"}, 64'({early, rsp_valid}), 64'b01);
      check({tag, "/result"}, 64'({rsp_id, rsp_cout, rsp_sum}),
            64'({exp_id, exp_cout, exp_sum}));
`ifdef ADD_SEQ_OVF_EN
      check({tag, "/ovf"}, 64'(rsp_ovf), 64'(exp_ovf));
`endif
      check({tag, "/ready_in_done"}, 64'({req0_ready, req1_ready}), 64'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "/hold"}, 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_sum}),
               64'({2'b00, 1'b1, exp_id, exp_cout, exp_sum}));
      end
      rsp_ready = 1'b1;
      #1;
      check({tag, "/no_accept_on_rsp"}, 64'({req0_ready, req1_ready}), 64'd0);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "/rsp_drop"}, 64'(rsp_valid), 64'd0);
   endtask

   task automatic run_model_txn(input logic v0, input logic v1, input int hold,
                                input string tag);
      logic [W-1:0] a0, b0, a1, b1, es;
      logic         s0, s1, gid, ec, eo;
      a0 = $urandom; b0 = $urandom; s0 = 1'($urandom);
      a1 = $urandom; b1 = $urandom; s1 = 1'($urandom);
      gid = (v0 && v1) ? prio : v1;
      if (gid) model(a1, b1, s1, es, ec, eo);
      else     model(a0, b0, s0, es, ec, eo);
      run_txn(v0, v1, a0, b0, s0, a1, b1, s1, gid, es, ec, eo, hold, tag);
   endtask

   initial begin
      logic early;
      int   pat;

      tbl[0] = '{1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0,
                 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0};
      tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1,
                 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
      tbl[2] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 1'b0,
                 1'b0, 32'h8000_0000, 1'b0, 1'b1, 5};
      tbl[3] = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h8000_0000, 32'h0000_0001,
                 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0};
      tbl[4] = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h8000_0000, 32'h0000_0001,
                 1'b1, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 2};
      tbl[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0,
                 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 0};
      tbl[6] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1,
                 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0};
      tbl[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'h0, 32'h0, 1'b0,
                 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};

      rst_n = 1'b1;
      req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      do_reset();

      // Directed vectors, applied back to back from reset.
      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].s0,
                 tbl[i].a1, tbl[i].b1, tbl[i].s1, tbl[i].id, tbl[i].sum,
                 tbl[i].cout, tbl[i].ovf, tbl[i].hold, $sformatf("vec%0d", i));
      end

      // Both requesters valid continuously from reset: grants alternate 0,1,0,1.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("alt%0d/prio", i), 64'(prio), 64'(i % 2));
         run_model_txn(1'b1, 1'b1, 0, $sformatf("alt%0d", i));
      end

      // Reset during the 4th CALC cycle aborts the job and rewinds the pointer.
      do_reset();
      req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_sub = 1'b0;
      req1_valid = 1'b0;
      #1;
      check("abort/accept", 64'({req0_ready, req1_ready}), 64'b10);
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort/reset_valid", 64'(rsp_valid), 64'd0);
      #1 rst_n = 1'b1;
      prio  = 1'b0;
      early = 1'b0;
      for (int k = 0; k < NIB + 3; k++) begin
         @(negedge clk);
         if (rsp_valid) early = 1'b1;
      end
      check("abort/no_response", 64'(early), 64'd0);
      run_model_txn(1'b1, 1'b1, 0, "abort/next");

      // Randomized traffic against the reference model.
      for (int i = 0; i < 40; i++) begin
         pat = $urandom_range(1, 3);
         run_model_txn(pat[0], pat[1], $urandom_range(0, 2), $sformatf("rnd%0d", i));
         if ($urandom_range(0, 3) == 0) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
